itf_host_link: RTL and testbench

ITF_HOST_LINK -- requirements
Module: itf_host_link

---
 rtl/itf_host_link_pkg.sv | 40 ++++
 rtl/itf_host_link_if.sv | 48 ++++
 rtl/itf_host_link_counter.sv | 22 ++
 rtl/itf_host_link.sv | 150 +++++++++++++++
 tb/tb_itf_host_link.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/itf_host_link_pkg.sv
// Shared definitions for the host link block and its off-chip host model:
// bus widths, FSM encoding, command-word layout.
package itf_host_link_pkg;

  localparam int PORT_WIDTH      = 128;  // off-chip beat width
  localparam int SRAM_WIDTH      = 256;  // internal word width
  localparam int DRAM_ADDR_WIDTH = 32;   // off-chip address
  localparam int ADDR_WIDTH      = 16;   // length field (in internal words)
  localparam int CNT_WIDTH       = ADDR_WIDTH + 1;  // beats = 2 * words

  // Command-word field offsets on the off-chip data bus
  localparam int CMD_DIR_BIT  = 0;
  localparam int CMD_ADDR_LSB = 1;
  localparam int CMD_LEN_LSB  = CMD_ADDR_LSB + DRAM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ISA  = 3'd1,
    CMD  = 3'd2,
    OUT  = 3'd3,
    IN   = 3'd4
  } state_e;

  typedef struct packed {
    logic                       dir;   // 1 = chip-to-off-chip
    logic [DRAM_ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0]      len;
  } req_t;

  // Place a latched request into the off-chip command word; unused bits are 0
  function automatic logic [PORT_WIDTH-1:0] pack_cmd(input req_t r);
    logic [PORT_WIDTH-1:0] w_cmd;
    w_cmd = '0;
    w_cmd[CMD_DIR_BIT]                       = r.dir;
    w_cmd[CMD_ADDR_LSB +: DRAM_ADDR_WIDTH]   = r.addr;
    w_cmd[CMD_LEN_LSB  +: ADDR_WIDTH]        = r.len;
    return w_cmd;
  endfunction

endpackage

// File: rtl/itf_host_link_if.sv
// Host link bus bundle: request handshake, internal read/write streams,
// ISA beat stream and the off-chip transmit/receive sides.
interface itf_host_link_if;
  import itf_host_link_pkg::*;

  // transfer request
  logic                       I_ReqVld, O_ReqRdy, I_ReqDir;
  logic [DRAM_ADDR_WIDTH-1:0] I_ReqAddr;
  logic [ADDR_WIDTH-1:0]      I_ReqLen;
  // internal outbound source
  logic [SRAM_WIDTH-1:0]      I_WrDat;
  logic                       I_WrVld, O_WrRdy;
  // internal inbound sink
  logic [SRAM_WIDTH-1:0]      O_RdDat;
  logic                       O_RdVld, I_RdRdy;
  // instruction beats to the configuration unit
  logic [PORT_WIDTH-1:0]      O_ISADat;
  logic                       O_ISAVld, I_ISARdy;
  // off-chip transmit
  logic                       O_CmdVld, O_DatOE, O_DatVld, O_DatLast, I_DatRdy;
  logic [PORT_WIDTH-1:0]      O_Dat;
  // off-chip receive
  logic [PORT_WIDTH-1:0]      I_Dat;
  logic                       I_DatVld, I_DatLast, I_ISAVld, O_DatRdy;
  // status
  logic                       O_Busy, O_LastErr;

  // Link block side
  modport slave (
    input  I_ReqVld, I_ReqDir, I_ReqAddr, I_ReqLen,
    input  I_WrDat, I_WrVld, I_RdRdy, I_ISARdy,
    input  I_DatRdy, I_Dat, I_DatVld, I_DatLast, I_ISAVld,
    output O_ReqRdy, O_WrRdy, O_RdDat, O_RdVld, O_ISADat, O_ISAVld,
    output O_CmdVld, O_DatOE, O_DatVld, O_DatLast, O_Dat, O_DatRdy,
    output O_Busy, O_LastErr
  );

  // Host / environment side
  modport master (
    output I_ReqVld, I_ReqDir, I_ReqAddr, I_ReqLen,
    output I_WrDat, I_WrVld, I_RdRdy, I_ISARdy,
    output I_DatRdy, I_Dat, I_DatVld, I_DatLast, I_ISAVld,
    input  O_ReqRdy, O_WrRdy, O_RdDat, O_RdVld, O_ISADat, O_ISAVld,
    input  O_CmdVld, O_DatOE, O_DatVld, O_DatLast, O_Dat, O_DatRdy,
    input  O_Busy, O_LastErr
  );

endinterface

// File: rtl/itf_host_link_counter.sv
// Loadable down-counter used to track remaining off-chip beats.
module itf_host_link_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // load wins over decrement; count never used below zero by the caller
  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/itf_host_link.sv
// Host link: accepts transfer requests, emits a command beat off-chip, then
// streams 256-bit internal words as pairs of 128-bit off-chip beats (OUT) or
// assembles inbound beat pairs into words (IN). Instruction beats arriving
// off-chip are forwarded to the configuration unit (ISA).
module itf_host_link
  import itf_host_link_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  itf_host_link_if.slave   io_host
);
  state_e                r_state, w_next;
  req_t                  r_req;
  logic [PORT_WIDTH-1:0] r_low;
  logic [SRAM_WIDTH-1:0] r_rddat;
  logic                  r_rdvld, r_lasterr;
  logic [CNT_WIDTH-1:0]  w_cnt;
  logic                  w_cnt_load, w_cnt_dec, w_odd, w_final;
  logic                  w_req_acc, w_in_hs, w_datrdy;

  // Counter holds remaining beats; since it starts even, its LSB is the
  // parity of the current beat and a value of 1 marks the final beat.
  assign w_odd   = w_cnt[0];
  assign w_final = (w_cnt == CNT_WIDTH'(1));

  itf_host_link_counter #(.W(CNT_WIDTH)) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val ({r_req.len, 1'b0}),
    .i_dec      (w_cnt_dec),
    .o_cnt      (w_cnt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next state and all combinational bus outputs
  always_comb begin
    w_next              = r_state;
    w_cnt_load          = 1'b0;
    w_cnt_dec           = 1'b0;
    w_req_acc           = 1'b0;
    w_in_hs             = 1'b0;
    w_datrdy            = 1'b0;
    io_host.O_ReqRdy    = 1'b0;
    io_host.O_CmdVld    = 1'b0;
    io_host.O_DatOE     = 1'b0;
    io_host.O_DatVld    = 1'b0;
    io_host.O_DatLast   = 1'b0;
    io_host.O_Dat       = '0;
    io_host.O_WrRdy     = 1'b0;
    io_host.O_ISADat    = '0;
    io_host.O_ISAVld    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // an arriving instruction beat pre-empts any pending request
        if (io_host.I_ISAVld && io_host.I_DatVld) begin
          w_next = ISA;
        end else begin
          io_host.O_ReqRdy = !rst;
          if (io_host.I_ReqVld && !rst) begin
            w_req_acc = 1'b1;
            if (io_host.I_ReqLen != '0) w_next = CMD;
          end
        end
      end
      CMD: begin
        io_host.O_CmdVld = 1'b1;
        io_host.O_DatVld = 1'b1;
        io_host.O_DatOE  = 1'b1;
        io_host.O_Dat    = pack_cmd(r_req);
        if (io_host.I_DatRdy) begin
          w_cnt_load = 1'b1;
          w_next     = r_req.dir ? OUT : IN;
        end
      end
      OUT: begin
        io_host.O_DatOE   = 1'b1;
        io_host.O_DatVld  = io_host.I_WrVld;
        io_host.O_Dat     = w_odd ? io_host.I_WrDat[SRAM_WIDTH-1:PORT_WIDTH]
                                  : io_host.I_WrDat[PORT_WIDTH-1:0];
        // the source word retires only once its upper half has gone out
        io_host.O_WrRdy   = io_host.I_DatRdy && w_odd;
        io_host.O_DatLast = w_final;
        if (io_host.I_WrVld && io_host.I_DatRdy) begin
          w_cnt_dec = 1'b1;
          if (w_final) w_next = IDLE;
        end
      end
      IN: begin
        // stall while an assembled word is still waiting for the sink
        w_datrdy = !r_rdvld || io_host.I_RdRdy;
        if (io_host.I_DatVld && w_datrdy) begin
          w_in_hs   = 1'b1;
          w_cnt_dec = 1'b1;
          if (w_final) w_next = IDLE;
        end
      end
      ISA: begin
        io_host.O_ISADat = io_host.I_Dat;
        io_host.O_ISAVld = io_host.I_DatVld;
        w_datrdy         = io_host.I_ISARdy;
        if (io_host.I_DatVld && io_host.I_ISARdy && io_host.I_DatLast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    io_host.O_DatRdy = w_datrdy;
  end

  // latch the accepted request (also for len==0, which is then discarded)
  always_ff @(posedge clk) begin
    if (rst)            r_req <= '0;
    else if (w_req_acc) r_req <= '{dir: io_host.I_ReqDir, addr: io_host.I_ReqAddr,
                                   len: io_host.I_ReqLen};
  end

  // inbound word assembly; a pending word survives into IDLE until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_low   <= '0;
      r_rddat <= '0;
      r_rdvld <= 1'b0;
    end else begin
      if (w_in_hs && !w_odd) r_low <= io_host.I_Dat;
      if (w_in_hs && w_odd) begin
        r_rddat <= {io_host.I_Dat, r_low};
        r_rdvld <= 1'b1;
      end else if (io_host.I_RdRdy) begin
        r_rdvld <= 1'b0;
      end
    end
  end

  // one-cycle error pulse: zero-length request or DatLast on the wrong beat
  always_ff @(posedge clk) begin
    if (rst) r_lasterr <= 1'b0;
    else     r_lasterr <= (w_req_acc && (io_host.I_ReqLen == '0)) ||
                          (w_in_hs && (io_host.I_DatLast != w_final));
  end

  assign io_host.O_RdDat   = r_rddat;
  assign io_host.O_RdVld   = r_rdvld;
  assign io_host.O_LastErr = r_lasterr;
  assign io_host.O_Busy    = (r_state != IDLE);

endmodule

// File: tb/tb_itf_host_link.sv
// Self-checking bench for itf_host_link: directed scenarios plus randomized
// IN/OUT transfers scored against a word/beat-level reference model.
module tb_itf_host_link;
  import itf_host_link_pkg::*;

  logic clk, rst;
  int   n_cmp, n_err;

  itf_host_link_if h();

  itf_host_link dut (
    .clk     (clk),
    .rst     (rst),
    .io_host (h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    h.I_ReqVld = 1'b0; h.I_ReqDir = 1'b0; h.I_ReqAddr = '0; h.I_ReqLen = '0;
    h.I_WrDat = '0; h.I_WrVld = 1'b0; h.I_RdRdy = 1'b0; h.I_ISARdy = 1'b0;
    h.I_DatRdy = 1'b0; h.I_Dat = '0; h.I_DatVld = 1'b0; h.I_DatLast = 1'b0;
    h.I_ISAVld = 1'b0;
  endtask

  // Issue a request from IDLE and walk through the command beat (one stall
  // cycle, then accept). Leaves the DUT in OUT/IN at posedge+1.
  task automatic do_req(input bit dir, input logic [31:0] addr, input int len);
    logic [PORT_WIDTH-1:0] exp_cmd;
    exp_cmd = '0;
    exp_cmd[48:0] = {16'(len), addr, dir};
    h.I_ReqVld = 1'b1; h.I_ReqDir = dir; h.I_ReqAddr = addr; h.I_ReqLen = 16'(len);
    #1;
    n_cmp++;
    if (h.O_ReqRdy !== 1'b1) begin
      n_err++; $display("FAIL req_rdy: got %b want 1", h.O_ReqRdy);
    end
    tick();
    h.I_ReqVld = 1'b0; h.I_DatRdy = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({h.O_CmdVld, h.O_DatVld, h.O_DatOE, h.O_DatLast} !== 4'b1110 || h.O_Dat !== exp_cmd) begin
        n_err++;
        $display("FAIL cmd_word[%0d]: got ctl=%b dat=%h want ctl=1110 dat=%h", k,
                 {h.O_CmdVld, h.O_DatVld, h.O_DatOE, h.O_DatLast}, h.O_Dat, exp_cmd);
      end
      if (k == 0) begin
        tick();
        h.I_DatRdy = 1'b1;
        #1;
      end
    end
    tick();
    h.I_DatRdy = 1'b0;
  endtask

  // Inbound transfer: beats pair up into words {odd, even}; err_beat (if in
  // range) gets its DatLast flag inverted and must produce an error pulse.
  task automatic run_in(input logic [31:0] addr, input int len, input int err_beat, input bit stall);
    logic [PORT_WIDTH-1:0] beats[$];
    logic [SRAM_WIDTH-1:0] exp_w[$];
    int sent, got, cyc;
    bit err_seen, err_exp;
    for (int i = 0; i < 2*len; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < len; k++) exp_w.push_back({beats[2*k+1], beats[2*k]});
    err_exp = (err_beat >= 0) && (err_beat < 2*len);
    do_req(1'b0, addr, len);
    sent = 0; got = 0; cyc = 0; err_seen = 1'b0;
    while ((sent < 2*len || got < len) && cyc < 1000) begin
      h.I_DatVld  = (sent < 2*len) && (!stall || $urandom_range(0, 3) != 0);
      h.I_Dat     = (sent < 2*len) ? beats[sent] : '0;
      h.I_DatLast = h.I_DatVld && ((sent == 2*len-1) != (sent == err_beat));
      h.I_RdRdy   = !stall || ($urandom_range(0, 1) == 1);
      #1;
      if (h.O_RdVld && h.I_RdRdy) begin
        n_cmp++;
        if (h.O_RdDat !== exp_w[got]) begin
          n_err++; $display("FAIL in_word[%0d]: got %h want %h", got, h.O_RdDat, exp_w[got]);
        end
        got++;
      end
      if (h.I_DatVld && h.O_DatRdy) begin
        if (sent == 0) begin
          n_cmp++;
          if (h.O_DatOE !== 1'b0) begin
            n_err++; $display("FAIL in_oe: got %b want 0", h.O_DatOE);
          end
        end
        sent++;
      end
      if (h.O_LastErr) err_seen = 1'b1;
      tick();
      cyc++;
    end
    h.I_DatVld = 1'b0; h.I_DatLast = 1'b0; h.I_RdRdy = 1'b0;
    #1;
    n_cmp++;
    if (cyc >= 1000) begin
      n_err++; $display("FAIL in_timeout: got sent=%0d words=%0d want sent=%0d words=%0d", sent, got, 2*len, len);
    end
    n_cmp++;
    if (err_seen !== err_exp) begin
      n_err++; $display("FAIL in_lasterr: got %b want %b", err_seen, err_exp);
    end
    n_cmp++;
    if ({h.O_Busy, h.O_DatRdy, h.O_RdVld} !== 3'b000) begin
      n_err++; $display("FAIL in_done: got busy/datrdy/rdvld=%b want 000", {h.O_Busy, h.O_DatRdy, h.O_RdVld});
    end
  endtask

  // Outbound transfer: each word goes out as low half then high half, the
  // last beat flagged, and the source sees exactly one retire per word.
  task automatic run_out(input logic [31:0] addr, input int len, input bit stall, input bit toggle);
    logic [SRAM_WIDTH-1:0] words[$];
    logic [PORT_WIDTH-1:0] exp_b[$];
    logic [SRAM_WIDTH-1:0] w;
    int wi, bi, cyc, nwr;
    for (int k = 0; k < len; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      words.push_back(w);
      exp_b.push_back(w[127:0]);
      exp_b.push_back(w[255:128]);
    end
    do_req(1'b1, addr, len);
    wi = 0; bi = 0; cyc = 0; nwr = 0;
    while (bi < 2*len && cyc < 1000) begin
      h.I_WrVld  = (wi < len) && (!stall || $urandom_range(0, 3) != 0);
      h.I_WrDat  = (wi < len) ? words[wi] : '0;
      h.I_DatRdy = toggle ? ((cyc % 2) == 1) : (!stall || ($urandom_range(0, 1) == 1));
      #1;
      if (h.O_DatVld && h.I_DatRdy) begin
        n_cmp++;
        if (h.O_Dat !== exp_b[bi] || h.O_DatLast !== (bi == 2*len-1) || h.O_DatOE !== 1'b1 || h.O_CmdVld !== 1'b0) begin
          n_err++;
          $display("FAIL out_beat[%0d]: got dat=%h last=%b oe=%b cmd=%b want dat=%h last=%b oe=1 cmd=0",
                   bi, h.O_Dat, h.O_DatLast, h.O_DatOE, h.O_CmdVld, exp_b[bi], (bi == 2*len-1));
        end
        bi++;
      end
      if (h.I_WrVld && h.O_WrRdy) begin
        wi++; nwr++;
      end
      tick();
      cyc++;
    end
    h.I_WrVld = 1'b0; h.I_DatRdy = 1'b0;
    #1;
    n_cmp++;
    if (cyc >= 1000) begin
      n_err++; $display("FAIL out_timeout: got beats=%0d want %0d", bi, 2*len);
    end
    n_cmp++;
    if (nwr != len) begin
      n_err++; $display("FAIL out_wrrdy: got %0d retires want %0d", nwr, len);
    end
    n_cmp++;
    if ({h.O_Busy, h.O_CmdVld, h.O_DatVld, h.O_DatLast} !== 4'b0000) begin
      n_err++; $display("FAIL out_done: got %b want 0000", {h.O_Busy, h.O_CmdVld, h.O_DatVld, h.O_DatLast});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    h.I_ReqVld = 1'b1; h.I_ReqLen = 16'd5;
    tick(); tick();
    #1;
    n_cmp++;
    if ({h.O_ReqRdy, h.O_Busy, h.O_RdVld, h.O_LastErr, h.O_CmdVld, h.O_DatVld, h.O_DatOE,
         h.O_DatRdy, h.O_WrRdy, h.O_ISAVld} !== 10'b0 || h.O_RdDat !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b rddat=%h want all 0",
               {h.O_ReqRdy, h.O_Busy, h.O_RdVld, h.O_LastErr, h.O_CmdVld, h.O_DatVld, h.O_DatOE,
                h.O_DatRdy, h.O_WrRdy, h.O_ISAVld}, h.O_RdDat);
    end
    rst = 1'b0;
    idle_in();
    tick();
  endtask

  task automatic test_in_basic();
    run_in(32'h100, 2, -1, 1'b0);
  endtask

  task automatic test_out_toggle();
    run_out($urandom, 1, 1'b0, 1'b1);
  endtask

  task automatic test_isa();
    logic [PORT_WIDTH-1:0] b[3];
    int idx, cyc;
    for (int i = 0; i < 3; i++) b[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0; cyc = 0;
    while (idx < 3 && cyc < 50) begin
      h.I_ISAVld = 1'b1; h.I_DatVld = 1'b1; h.I_Dat = b[idx]; h.I_DatLast = (idx == 2);
      h.I_ISARdy = !(cyc == 2 || cyc == 3);
      #1;
      if (cyc == 0) begin
        n_cmp++;
        if (h.O_ReqRdy !== 1'b0 || h.O_ISAVld !== 1'b0) begin
          n_err++; $display("FAIL isa_idle: got reqrdy=%b isavld=%b want 0 0", h.O_ReqRdy, h.O_ISAVld);
        end
      end
      if (cyc == 2) begin
        n_cmp++;
        if (h.O_ISAVld !== 1'b1 || h.O_DatRdy !== 1'b0) begin
          n_err++; $display("FAIL isa_stall: got isavld=%b datrdy=%b want 1 0", h.O_ISAVld, h.O_DatRdy);
        end
      end
      if (h.O_ISAVld && h.I_ISARdy) begin
        n_cmp++;
        if (h.O_ISADat !== b[idx] || h.O_DatRdy !== 1'b1) begin
          n_err++; $display("FAIL isa_beat[%0d]: got %h rdy=%b want %h rdy=1", idx, h.O_ISADat, h.O_DatRdy, b[idx]);
        end
        idx++;
      end
      tick();
      cyc++;
    end
    idle_in();
    #1;
    n_cmp++;
    if (idx != 3 || cyc != 6 || h.O_Busy !== 1'b0 || h.O_ReqRdy !== 1'b1) begin
      n_err++; $display("FAIL isa_done: got beats=%0d cycles=%0d busy=%b reqrdy=%b want 3 6 0 1",
                        idx, cyc, h.O_Busy, h.O_ReqRdy);
    end
  endtask

  task automatic test_isa_priority();
    h.I_ISAVld = 1'b1; h.I_DatVld = 1'b1; h.I_Dat = {$urandom, $urandom, $urandom, $urandom};
    h.I_DatLast = 1'b1; h.I_ISARdy = 1'b1;
    h.I_ReqVld = 1'b1; h.I_ReqDir = 1'b1; h.I_ReqAddr = $urandom; h.I_ReqLen = 16'd1;
    #1;
    n_cmp++;
    if (h.O_ReqRdy !== 1'b0) begin
      n_err++; $display("FAIL prio_idle: got reqrdy=%b want 0", h.O_ReqRdy);
    end
    tick();
    #1;
    n_cmp++;
    if ({h.O_ISAVld, h.O_ReqRdy, h.O_CmdVld, h.O_Busy} !== 4'b1001) begin
      n_err++; $display("FAIL prio_isa: got isavld/reqrdy/cmdvld/busy=%b want 1001",
                        {h.O_ISAVld, h.O_ReqRdy, h.O_CmdVld, h.O_Busy});
    end
    tick();
    h.I_ISAVld = 1'b0; h.I_DatVld = 1'b0; h.I_DatLast = 1'b0;
    #1;
    n_cmp++;
    if ({h.O_ReqRdy, h.O_Busy} !== 2'b10) begin
      n_err++; $display("FAIL prio_back: got reqrdy/busy=%b want 10", {h.O_ReqRdy, h.O_Busy});
    end
    idle_in();
    tick();
    #1;
    n_cmp++;
    if ({h.O_CmdVld, h.O_Busy} !== 2'b00) begin
      n_err++; $display("FAIL prio_noreq: got cmdvld/busy=%b want 00", {h.O_CmdVld, h.O_Busy});
    end
  endtask

  task automatic test_len0();
    h.I_ReqVld = 1'b1; h.I_ReqDir = 1'($urandom_range(0, 1)); h.I_ReqAddr = $urandom; h.I_ReqLen = '0;
    #1;
    n_cmp++;
    if (h.O_ReqRdy !== 1'b1) begin
      n_err++; $display("FAIL len0_rdy: got %b want 1", h.O_ReqRdy);
    end
    tick();
    h.I_ReqVld = 1'b0;
    #1;
    n_cmp++;
    if ({h.O_LastErr, h.O_CmdVld, h.O_Busy} !== 3'b100) begin
      n_err++; $display("FAIL len0_pulse: got err/cmd/busy=%b want 100", {h.O_LastErr, h.O_CmdVld, h.O_Busy});
    end
    tick();
    #1;
    n_cmp++;
    if ({h.O_LastErr, h.O_CmdVld, h.O_Busy} !== 3'b000) begin
      n_err++; $display("FAIL len0_after: got err/cmd/busy=%b want 000", {h.O_LastErr, h.O_CmdVld, h.O_Busy});
    end
  endtask

  task automatic test_in_lasterr();
    run_in($urandom, 2, 1, 1'b0);
  endtask

  task automatic test_reset_mid_out();
    logic [SRAM_WIDTH-1:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_req(1'b1, 32'h2000, 2);
    h.I_WrVld = 1'b1; h.I_WrDat = w; h.I_DatRdy = 1'b1;
    #1;
    n_cmp++;
    if (h.O_Dat !== w[127:0]) begin
      n_err++; $display("FAIL rst_out_b0: got %h want %h", h.O_Dat, w[127:0]);
    end
    tick();
    rst = 1'b1;
    tick();
    #1;
    n_cmp++;
    if ({h.O_Busy, h.O_CmdVld, h.O_DatVld, h.O_DatOE, h.O_DatLast, h.O_WrRdy, h.O_DatRdy,
         h.O_ReqRdy, h.O_RdVld, h.O_LastErr, h.O_ISAVld} !== 11'b0 || h.O_Dat !== '0) begin
      n_err++;
      $display("FAIL rst_mid_out: got %b dat=%h want all 0",
               {h.O_Busy, h.O_CmdVld, h.O_DatVld, h.O_DatOE, h.O_DatLast, h.O_WrRdy, h.O_DatRdy,
                h.O_ReqRdy, h.O_RdVld, h.O_LastErr, h.O_ISAVld}, h.O_Dat);
    end
    rst = 1'b0;
    idle_in();
    tick();
    run_out(32'h3000, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int len, eb;
      len = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        run_out($urandom, len, 1'b1, 1'b0);
      end else begin
        eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2*len-1)) : -1;
        run_in($urandom, len, eb, 1'b1);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_in();
    test_reset();
    test_in_basic();
    test_out_toggle();
    test_isa();
    test_isa_priority();
    test_len0();
    test_in_lasterr();
    test_reset_mid_out();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
